// File: rtl/env_ramp_engine.sv
// Per-slot four-segment linear envelope engine, two-stage pipeline.
// Optional ENV_HARD_RETRIGGER_EN: gate rising edge restarts attack from 0.
module env_ramp_engine #(
    parameter int VOICES  = 8,
    parameter int V_ENVS  = 8,
    parameter int V_WIDTH = 3,
    parameter int E_WIDTH = 3,
    parameter int L_WIDTH = 16
) (
    input  logic                       sCLK_XVXENVS,
    input  logic                       reset_reg,
    input  logic [V_WIDTH+E_WIDTH-1:0] xxxx,
    input  logic                       n_xxxx_zero,
    input  logic [VOICES-1:0]          gate,
    input  logic [L_WIDTH-1:0]         attack_rate,
    input  logic [L_WIDTH-1:0]         decay_rate,
    input  logic [L_WIDTH-1:0]         sustain_level,
    input  logic [L_WIDTH-1:0]         release_rate,
    output logic [L_WIDTH-1:0]         env_level,
    output logic [V_WIDTH+E_WIDTH-1:0] env_idx,
    output logic                       env_valid,
    output logic [VOICES-1:0]          voice_active
);

    localparam int SLOTS   = VOICES * V_ENVS;
    localparam int I_WIDTH = V_WIDTH + E_WIDTH;
    localparam logic [L_WIDTH-1:0] LMAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } env_state_t;

    env_state_t         st_mem [SLOTS];
    logic [L_WIDTH-1:0] lv_mem [SLOTS];
    logic [SLOTS-1:0]   pg_mem;

    logic [VOICES-1:0]  gate_frame;
    logic [I_WIDTH-1:0] idx0;
    logic               g0;
    logic               valid0;

    env_state_t         st_cur;
    env_state_t         st_nxt;
    logic [L_WIDTH-1:0] lv_cur;
    logic [L_WIDTH-1:0] lv_base;
    logic [L_WIDTH-1:0] lv_nxt;
    logic               pg_cur;
    logic               rise;
    logic               fall;
    logic [L_WIDTH:0]   att_sum;
    logic [L_WIDTH:0]   dec_floor;

    // Stage 0: latch index and the frame-stable gate of its voice
    always_ff @(posedge sCLK_XVXENVS or posedge reset_reg) begin
        if (reset_reg) begin
            gate_frame <= '0;
            idx0       <= '0;
            g0         <= 1'b0;
            valid0     <= 1'b0;
        end else begin
            if (n_xxxx_zero)
                gate_frame <= gate;
            idx0   <= xxxx;
            g0     <= gate_frame[xxxx[I_WIDTH-1:E_WIDTH]];
            valid0 <= 1'b1;
        end
    end

    always_comb begin
        st_cur = st_mem[idx0];
        lv_cur = lv_mem[idx0];
        pg_cur = pg_mem[idx0];
        st_nxt = st_cur;
        lv_nxt = lv_cur;
        rise   = g0 && !pg_cur;
        fall   = !g0 && pg_cur && (st_cur != IDLE);
`ifdef ENV_HARD_RETRIGGER_EN
        lv_base = rise ? '0 : lv_cur;
`else
        lv_base = lv_cur;
`endif
        att_sum   = {1'b0, lv_base} + {1'b0, attack_rate};
        dec_floor = {1'b0, sustain_level} + {1'b0, decay_rate};
        if (fall) begin
            st_nxt = RELEASE;
        end else if (rise || st_cur == ATTACK) begin
            st_nxt = ATTACK;
            lv_nxt = lv_base;
            if (attack_rate != '0) begin
                if (att_sum >= {1'b0, LMAX}) begin
                    lv_nxt = LMAX;
                    st_nxt = DECAY;
                end else begin
                    lv_nxt = att_sum[L_WIDTH-1:0];
                end
            end
        end else begin
            case (st_cur)
                DECAY: begin
                    if ({1'b0, lv_cur} <= dec_floor) begin
                        lv_nxt = sustain_level;
                        st_nxt = SUSTAIN;
                    end else begin
                        lv_nxt = lv_cur - decay_rate;
                    end
                end
                SUSTAIN: lv_nxt = sustain_level;
                RELEASE: begin
                    // zero rate freezes the release instead of snapping to 0
                    if (release_rate != '0) begin
                        if (lv_cur <= release_rate) begin
                            lv_nxt = '0;
                            st_nxt = IDLE;
                        end else begin
                            lv_nxt = lv_cur - release_rate;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage 1: write back slot state and present the new level
    always_ff @(posedge sCLK_XVXENVS or posedge reset_reg) begin
        if (reset_reg) begin
            for (int i = 0; i < SLOTS; i++) begin
                st_mem[i] <= IDLE;
                lv_mem[i] <= '0;
            end
            pg_mem    <= '0;
            env_level <= '0;
            env_idx   <= '0;
            env_valid <= 1'b0;
        end else begin
            if (valid0) begin
                st_mem[idx0] <= st_nxt;
                lv_mem[idx0] <= lv_nxt;
                pg_mem[idx0] <= g0;
            end
            env_level <= lv_nxt;
            env_idx   <= idx0;
            env_valid <= valid0;
        end
    end

    always_comb begin
        voice_active = '0;
        for (int s = 0; s < SLOTS; s++) begin
            if (st_mem[s] != IDLE)
                voice_active[s / V_ENVS] = 1'b1;
        end
    end

endmodule
